// File: rtl/colour_sensor_pkg.sv
// Shared types and constants for the colour-sensor emulator.
//   state_t     : PDOWN / SETTLE / RUN
//   FLT_*       : filter codes decoded from {S3,S2}
//   SCL_*       : scale codes decoded from {S1,S0}
//   MULT_*      : half-period multipliers for each scale
//   scale_mult  : maps a scale code to its multiplier (0 for power-down)
package colour_sensor_pkg;

    typedef enum logic [1:0] {PDOWN, SETTLE, RUN} state_t;

    localparam logic [1:0] FLT_RED   = 2'b00;
    localparam logic [1:0] FLT_CLEAR = 2'b01;
    localparam logic [1:0] FLT_BLUE  = 2'b10;
    localparam logic [1:0] FLT_GREEN = 2'b11;

    localparam logic [1:0] SCL_PDOWN  = 2'b00;
    localparam logic [1:0] SCL_2PCT   = 2'b10;
    localparam logic [1:0] SCL_20PCT  = 2'b01;
    localparam logic [1:0] SCL_100PCT = 2'b11;

    localparam logic [5:0] MULT_2PCT   = 6'd50;
    localparam logic [5:0] MULT_20PCT  = 6'd5;
    localparam logic [5:0] MULT_100PCT = 6'd1;

    function automatic logic [5:0] scale_mult(input logic [1:0] scl);
        logic [5:0] m;
        m = 6'd0;
        case (scl)
            SCL_2PCT:   m = MULT_2PCT;
            SCL_20PCT:  m = MULT_20PCT;
            SCL_100PCT: m = MULT_100PCT;
            default:    m = 6'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/colour_sensor_emulator_sq_gen.sv
// Square-wave generator: half-period down-counter, sq toggle and reload.
//   clk, rst : clock, async active-high reset
//   shp      : scaled half-period in clk cycles (0 = hold low)
//   run      : advance the wave this cycle
//   clr      : sync clear of the wave level (select change)
//   load     : start a fresh low phase of length shp
//   sq       : square-wave level (registered)
//   rise     : sq goes 0->1 at the coming clk edge
module colour_sq_gen #(
    parameter int CW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] shp,
    input  logic          run,
    input  logic          clr,
    input  logic          load,
    output logic          sq,
    output logic          rise
);

    logic [CW-1:0] half_cnt;
    // Set while shp==0 has parked the wave; the first nonzero shp then
    // starts a fresh low phase instead of toggling.
    logic          pend;
    logic          shp_zero;

    assign shp_zero = (shp == '0);
    assign rise     = run & ~clr & ~load & ~shp_zero & ~pend
                    & (half_cnt == '0) & ~sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq       <= 1'b0;
            half_cnt <= '0;
            pend     <= 1'b0;
        end else if (clr) begin
            sq <= 1'b0;
        end else if (load) begin
            sq <= 1'b0;
            if (shp_zero) begin
                half_cnt <= '0;
                pend     <= 1'b1;
            end else begin
                half_cnt <= shp - 1'b1;
                pend     <= 1'b0;
            end
        end else if (run) begin
            if (shp_zero) begin
                sq       <= 1'b0;
                half_cnt <= '0;
                pend     <= 1'b1;
            end else if (pend) begin
                half_cnt <= shp - 1'b1;
                pend     <= 1'b0;
            end else if (half_cnt == '0) begin
                sq       <= ~sq;
                half_cnt <= shp - 1'b1;
            end else begin
                half_cnt <= half_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/colour_sensor_emulator.sv
// Stand-in colour sensor: captures the select lines, settles after each
// change, then drives a square wave whose half-period is the programmed
// value for the selected filter times the scale multiplier.
//   clk, rst       : clock, async active-high reset
//   s[3:0]         : {S3,S2} filter, {S1,S0} scale
//   OE             : active-low output enable
//   hp_red..clear  : per-channel half-periods at 100% scaling
//   freq, freq_oe  : gated square wave and its tri-state enable
//   settling       : high while in SETTLE
//   edge_cnt       : rising edges of the wave seen while enabled
module colour_sensor_emulator
    import colour_sensor_pkg::*;
#(
    parameter int HP_W       = 16,
    parameter int SETTLE_CYC = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      s,
    input  logic            OE,
    input  logic [HP_W-1:0] hp_red,
    input  logic [HP_W-1:0] hp_green,
    input  logic [HP_W-1:0] hp_blue,
    input  logic [HP_W-1:0] hp_clear,
    output logic            freq,
    output logic            freq_oe,
    output logic            settling,
    output logic [15:0]     edge_cnt
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int CW = HP_W + 6;

    state_t          state_q, state_d;
    logic [3:0]      s_q;
    logic [SW-1:0]   settle_cnt;
    logic            changed;
    logic            load;
    logic            sq;
    logic            rise;
    logic [HP_W-1:0] hp_sel;
    logic [CW-1:0]   shp;

    assign changed = (s != s_q);

    always_comb begin
        hp_sel = hp_red;
        case (s_q[3:2])
            FLT_RED:   hp_sel = hp_red;
            FLT_CLEAR: hp_sel = hp_clear;
            FLT_BLUE:  hp_sel = hp_blue;
            FLT_GREEN: hp_sel = hp_green;
            default:   hp_sel = hp_red;
        endcase
    end

    // Full-width product: 50 * (2^HP_W - 1) fits in HP_W+6 bits.
    assign shp = {6'd0, hp_sel} * {{HP_W{1'b0}}, scale_mult(s_q[1:0])};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (changed) begin
            state_d = (s[1:0] == SCL_PDOWN) ? PDOWN : SETTLE;
        end else begin
            case (state_q)
                SETTLE: if (settle_cnt == '0) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PDOWN;
            s_q        <= 4'b0000;
            settle_cnt <= '0;
            edge_cnt   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (changed) begin
                s_q        <= s;
                settle_cnt <= SW'(SETTLE_CYC - 1);
            end else if (state_q == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (rise && !OE)
                edge_cnt <= edge_cnt + 16'd1;
        end
    end

    colour_sq_gen #(.CW(CW)) u_sq_gen (
        .clk  (clk),
        .rst  (rst),
        .shp  (shp),
        .run  (state_q == RUN),
        .clr  (changed),
        .load (load),
        .sq   (sq),
        .rise (rise)
    );

    // OE only gates the pins; the wave keeps running so phase survives.
    assign freq     = sq & ~OE;
    assign freq_oe  = ~OE & (state_q != PDOWN);
    assign settling = (state_q == SETTLE);

endmodule
